// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: fetch-priority, loader starvation guard and loader burst ownership.
// Latency: grant is combinational, response valid one cycle later; backpressure: the loser is held via o_Stall / no o_LdGnt.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_AW     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_FetchReq,
    input  logic [ADDR_W-1:0] i_FetchAddr,
    output logic              o_FetchGnt,
    output logic              o_FetchValid,
    output logic [31:0]       o_FetchInstr,
    output logic              o_FetchMisalign,
    output logic              o_Stall,
    input  logic              i_LdReq,
    input  logic              i_LdWe,
    input  logic              i_LdHold,
    input  logic [ADDR_W-1:0] i_LdAddr,
    input  logic [31:0]       i_LdWData,
    output logic              o_LdGnt,
    output logic              o_LdValid,
    output logic [31:0]       o_LdRData,
    output logic              o_MemEn,
    output logic              o_MemWe,
    output logic [MEM_AW-1:0] o_MemAddr,
    output logic [31:0]       o_MemWData,
    input  logic [31:0]       i_MemRData
);

    typedef enum logic {S_FETCH, S_LOAD} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state, state_nxt;
    logic [3:0]  starve_cnt, starve_nxt;
    logic        burst;
    logic        fetch_gnt, ld_gnt;
    logic        fetch_pend, ld_pend, fetch_mis_q;
    logic [31:0] fetch_instr_q, ld_rdata_q;

    // Only the word index within the memory is decoded; the rest wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_FetchAddr[ADDR_W-1:MEM_AW+2], i_LdAddr[ADDR_W-1:MEM_AW+2], i_LdAddr[1:0]};

    always_comb begin
        fetch_gnt  = 1'b0;
        ld_gnt     = 1'b0;
        starve_nxt = 4'd0;
        // Dropping hold releases the burst in the same cycle, before arbitration.
        burst      = (state == S_LOAD) && i_LdHold;
        if (i_Rst_n) begin
            if (burst) begin
                ld_gnt    = i_LdReq;
                fetch_gnt = i_FetchReq && !i_LdReq;
            end else begin
                fetch_gnt = i_FetchReq && (starve_cnt < STARVE_LIM);
                ld_gnt    = i_LdReq && !fetch_gnt;
            end
        end
        state_nxt = (burst || (ld_gnt && i_LdHold)) ? S_LOAD : S_FETCH;
        if (i_LdReq && !ld_gnt) begin
            starve_nxt = (starve_cnt < STARVE_LIM) ? starve_cnt + 4'd1 : starve_cnt;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= S_FETCH;
            starve_cnt    <= 4'd0;
            fetch_pend    <= 1'b0;
            ld_pend       <= 1'b0;
            fetch_mis_q   <= 1'b0;
            fetch_instr_q <= 32'd0;
            ld_rdata_q    <= 32'd0;
        end else begin
            state       <= state_nxt;
            starve_cnt  <= starve_nxt;
            fetch_pend  <= fetch_gnt;
            ld_pend     <= ld_gnt && !i_LdWe;
            fetch_mis_q <= fetch_gnt && (i_FetchAddr[1:0] != 2'b00);
            if (fetch_pend) fetch_instr_q <= i_MemRData;
            if (ld_pend)    ld_rdata_q    <= i_MemRData;
        end
    end

    always_comb begin
        o_MemAddr  = '0;
        o_MemWData = 32'd0;
        if (ld_gnt) begin
            o_MemAddr  = i_LdAddr[MEM_AW+1:2];
            o_MemWData = i_LdWData;
        end else if (fetch_gnt) begin
            o_MemAddr  = i_FetchAddr[MEM_AW+1:2];
        end
    end

    assign o_FetchGnt      = fetch_gnt;
    assign o_LdGnt         = ld_gnt;
    assign o_MemEn         = fetch_gnt || ld_gnt;
    assign o_MemWe         = ld_gnt && i_LdWe;
    assign o_Stall         = i_Rst_n && i_FetchReq && !fetch_gnt;
    assign o_FetchValid    = fetch_pend;
    assign o_LdValid       = ld_pend;
    assign o_FetchMisalign = fetch_mis_q;
    // The macro's read port is already a register, so data passes through in the response cycle and is held afterwards.
    assign o_FetchInstr    = fetch_pend ? i_MemRData : fetch_instr_q;
    assign o_LdRData       = ld_pend    ? i_MemRData : ld_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: synchronous-read memory macro, cycle-level reference model and directed scenarios.
module tb_imem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int MEM_AW     = 6;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_gnt, fetch_valid, fetch_mis, stall;
    logic [31:0]       fetch_instr;
    logic              ld_req = 1'b0, ld_we = 1'b0, ld_hold = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [31:0]       ld_wdata = 32'd0;
    logic              ld_gnt, ld_valid;
    logic [31:0]       ld_rdata;
    logic              mem_en, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .i_FetchReq(fetch_req), .i_FetchAddr(fetch_addr), .o_FetchGnt(fetch_gnt),
        .o_FetchValid(fetch_valid), .o_FetchInstr(fetch_instr), .o_FetchMisalign(fetch_mis),
        .o_Stall(stall),
        .i_LdReq(ld_req), .i_LdWe(ld_we), .i_LdHold(ld_hold), .i_LdAddr(ld_addr),
        .i_LdWData(ld_wdata), .o_LdGnt(ld_gnt), .o_LdValid(ld_valid), .o_LdRData(ld_rdata),
        .o_MemEn(mem_en), .o_MemWe(mem_we), .o_MemAddr(mem_addr), .o_MemWData(mem_wdata),
        .i_MemRData(mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] img(input int i);
        return 32'h1300_0013 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // Memory macro: one access per cycle, read data registered.
    logic [31:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = img(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) mem[mem_addr] <= mem_wdata;
                else        mem_rdata     <= mem[mem_addr];
            end
        end
    end

    // Reference model, evaluated once per cycle on the falling edge.
    logic [31:0] ref_mem [DEPTH];
    bit          m_burst, e_fv, e_mis, e_lv;
    int          m_denied;
    logic [31:0] e_finstr, e_ldr;
    initial begin
        bit fg, lg, bn;
        int fi, li, ea;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = img(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_fetch_gnt", 32'(fetch_gnt), 0);
                chk("rst_ld_gnt", 32'(ld_gnt), 0);
                chk("rst_stall", 32'(stall), 0);
                chk("rst_mem_en", 32'(mem_en), 0);
                chk("rst_mem_we", 32'(mem_we), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_mem_wdata", mem_wdata, 0);
                chk("rst_fetch_valid", 32'(fetch_valid), 0);
                chk("rst_fetch_mis", 32'(fetch_mis), 0);
                chk("rst_ld_valid", 32'(ld_valid), 0);
                chk("rst_fetch_instr", fetch_instr, 0);
                chk("rst_ld_rdata", ld_rdata, 0);
                m_burst = 0; m_denied = 0;
                e_fv = 0; e_mis = 0; e_lv = 0; e_finstr = 0; e_ldr = 0;
            end else begin
                chk("m_fetch_valid", 32'(fetch_valid), 32'(e_fv));
                chk("m_fetch_mis", 32'(fetch_mis), 32'(e_mis));
                chk("m_fetch_instr", fetch_instr, e_finstr);
                chk("m_ld_valid", 32'(ld_valid), 32'(e_lv));
                chk("m_ld_rdata", ld_rdata, e_ldr);
                bn = m_burst && ld_hold;
                if (bn) begin
                    lg = ld_req;
                    fg = fetch_req && !ld_req;
                end else begin
                    fg = fetch_req && (m_denied < STARVE_MAX);
                    lg = ld_req && !fg;
                end
                fi = int'((fetch_addr % 32'd256) / 32'd4);
                li = int'((ld_addr % 32'd256) / 32'd4);
                ea = lg ? li : (fg ? fi : 0);
                chk("m_fetch_gnt", 32'(fetch_gnt), 32'(fg));
                chk("m_ld_gnt", 32'(ld_gnt), 32'(lg));
                chk("m_stall", 32'(stall), 32'(fetch_req && !fg));
                chk("m_mem_en", 32'(mem_en), 32'(fg || lg));
                chk("m_mem_we", 32'(mem_we), 32'(lg && ld_we));
                chk("m_mem_addr", 32'(mem_addr), 32'(ea));
                chk("m_mem_wdata", mem_wdata, lg ? ld_wdata : 32'd0);
                e_fv  = fg;
                e_mis = fg && ((fetch_addr % 32'd4) != 0);
                if (fg) e_finstr = ref_mem[fi];
                e_lv  = lg && !ld_we;
                if (e_lv) e_ldr = ref_mem[li];
                if (lg && ld_we) ref_mem[li] = ld_wdata;
                if (ld_req && !lg) m_denied = (m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1;
                else               m_denied = 0;
                m_burst = bn || (lg && ld_hold);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit g;
        int ngnt, nstall, gap, k;
        bit got;
        logic [31:0] exp;

        // Reset with a fetch request pending: all grants must stay low.
        fetch_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Starvation: loader wins in cycle 5, fetch back in cycle 6.
        fetch_addr = 32'h0; ld_req = 1'b1; ld_addr = 32'h20; ld_we = 1'b0; ld_hold = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            g = ld_gnt;
            if (c < 5) chk("t1_fetch_wins", 32'(fetch_gnt), 1);
            if (c == 5) begin
                chk("t1_ld_cycle5", 32'(ld_gnt), 1);
                chk("t1_stall_cycle5", 32'(stall), 1);
            end else begin
                chk("t1_no_stall", 32'(stall), 0);
            end
            if (c == 6) chk("t1_fetch_cycle6", 32'(fetch_gnt), 1);
            cyc();
            if (g) ld_req = 1'b0;
        end
        fetch_req = 1'b0;

        // Loader write then fetch of the same word.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h10; ld_wdata = 32'h0050_0093;
        @(negedge clk);
        chk("t2_ld_gnt", 32'(ld_gnt), 1);
        chk("t2_mem_we", 32'(mem_we), 1);
        chk("t2_mem_addr", 32'(mem_addr), 4);
        cyc();
        ld_req = 1'b0; ld_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h10;
        @(negedge clk);
        chk("t2_fetch_gnt", 32'(fetch_gnt), 1);
        cyc();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("t2_fetch_valid", 32'(fetch_valid), 1);
        chk("t2_fetch_instr", fetch_instr, 32'h0050_0093);
        cyc();

        // Loader burst of 8 reads against a continuously requesting fetch.
        ld_req = 1'b1; ld_we = 1'b0; ld_hold = 1'b1; ld_addr = 32'h0;
        fetch_req = 1'b1; fetch_addr = 32'h4;
        ngnt = 0; nstall = 0; gap = 0;
        for (int c = 0; c < 40 && ngnt < 8; c++) begin
            @(negedge clk);
            g = ld_gnt;
            if (g) begin
                ngnt++;
                if (stall) nstall++;
            end else if (ngnt > 0) begin
                gap++;
            end
            cyc();
            if (g) ld_addr = ld_addr + 32'd4;
            if (ngnt == 8) begin
                ld_hold = 1'b0;
                ld_addr = 32'h40;
            end
        end
        chk("t3_ld_grants", 32'(ngnt), 8);
        chk("t3_stalls", 32'(nstall), 8);
        chk("t3_gaps", 32'(gap), 0);
        @(negedge clk);
        chk("t3_fetch_after_hold", 32'(fetch_gnt), 1);
        chk("t3_ld_waits", 32'(ld_gnt), 0);
        cyc();
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = ld_gnt;
            cyc();
        end
        chk("t3_ld_eventually", 32'(got), 1);
        ld_req = 1'b0; fetch_req = 1'b0;
        cyc();

        // Misaligned, wrapped fetch.
        fetch_req = 1'b1; fetch_addr = 32'h0000_0102;
        @(negedge clk);
        chk("t4_fetch_gnt", 32'(fetch_gnt), 1);
        chk("t4_mem_addr", 32'(mem_addr), 0);
        cyc();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("t4_valid", 32'(fetch_valid), 1);
        chk("t4_misalign", 32'(fetch_mis), 1);
        chk("t4_instr", fetch_instr, img(0));
        cyc();

        // Reset directly after a fetch grant made while in burst ownership.
        ld_req = 1'b1; ld_hold = 1'b1; ld_we = 1'b0; ld_addr = 32'h8;
        @(negedge clk);
        chk("t5_ld_gnt", 32'(ld_gnt), 1);
        cyc();
        ld_req = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h8;
        @(negedge clk);
        chk("t5_fetch_in_burst", 32'(fetch_gnt), 1);
        cyc();
        rst_n = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        chk("t5_no_valid_in_rst", 32'(fetch_valid), 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_valid_after", 32'(fetch_valid), 0);
        chk("t5_mis_zero", 32'(fetch_mis), 0);
        chk("t5_instr_zero", fetch_instr, 0);
        chk("t5_ldr_zero", ld_rdata, 0);
        cyc();
        ld_req = 1'b1; ld_addr = 32'h0; fetch_req = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        chk("t5_state_fetch", 32'(fetch_gnt), 1);
        chk("t5_ld_denied", 32'(ld_gnt), 0);
        cyc();
        ld_req = 1'b0; ld_hold = 1'b0; fetch_req = 1'b0;
        cyc();

        // Back-to-back sweep of the whole memory.
        k = 0;
        for (int c = 0; c < 66; c++) begin
            if (c < 64) begin
                fetch_req  = 1'b1;
                fetch_addr = 32'(c * 4);
            end else begin
                fetch_req  = 1'b0;
            end
            @(negedge clk);
            if (fetch_valid) begin
                exp = (k == 4) ? 32'h0050_0093 : img(k);
                chk("t6_data", fetch_instr, exp);
                k++;
            end
            cyc();
        end
        chk("t6_count", 32'(k), 64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
